// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - byte/half/word load-store unit with sub-word read-modify-write in front of the word-wide data memory; optional MEM_LSU_ADDR_CHECK_EN
`ifndef WORD
`define WORD 32
`endif
`ifndef ADDR
`define ADDR 16
`endif

module mem_lsu #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [`ADDR+1:0]  req_addr,
  input  logic [`WORD-1:0]  req_wdata,
  output logic              resp_valid,
  output logic [`WORD-1:0]  resp_rdata,
  output logic              resp_err,
  output logic [`ADDR-1:0]  mem_A,
  output logic              mem_W,
  output logic [`WORD-1:0]  mem_D,
  input  logic [`WORD-1:0]  mem_Q,
  input  logic [`ADDR-1:0]  mem_Ao
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_RESP  = 3'd1,
    MERGE    = 3'd2,
    ST_RESP  = 3'd3,
    ERR_RESP = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [`ADDR-1:0]   waddr_q;
  logic [1:0]         lane_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [`WORD-1:0]   wdata_q;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [`WORD-1:0]   resp_rdata_q, resp_rdata_d;

  logic               accept;
  logic               req_illegal;
  logic               req_trap;
  logic               req_is_word;
  logic [1:0]         req_lane;
  logic [`ADDR-1:0]   req_waddr;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [`WORD-1:0]   ld_data;
  logic [`WORD-1:0]   merged;
  logic               ao_bad;

  assign req_waddr   = req_addr[`ADDR+1:2];
  // Size 11 is treated as a word access when trapping is disabled.
  assign req_is_word = req_size[1];
  assign req_illegal = (req_size == 2'b11) ||
                       (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_trap    = MISALIGN_TRAP && req_illegal;
  // Lane forced down to the natural alignment of the access size.
  assign req_lane    = req_is_word ? 2'b00 :
                       (req_size == 2'b01) ? {req_addr[1], 1'b0} : req_addr[1:0];

  // No new request while a response pulse is on the bus.
  assign req_ready   = rst_n && (state_q == IDLE) && !resp_valid_q;
  assign accept      = req_valid && req_ready;

`ifdef MEM_LSU_ADDR_CHECK_EN
  assign ao_bad = (mem_Ao != waddr_q);
`else
  logic unused_ao;
  assign unused_ao = ^mem_Ao;
  assign ao_bad    = 1'b0;
`endif

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    ld_byte = mem_Q[{lane_q, 3'b000} +: 8];
    ld_half = mem_Q[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_data = uns_q ? {{(`WORD-8){1'b0}}, ld_byte}
                               : {{(`WORD-8){ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = uns_q ? {{(`WORD-16){1'b0}}, ld_half}
                               : {{(`WORD-16){ld_half[15]}}, ld_half};
      default: ld_data = mem_Q;
    endcase
  end

  // Replace the target lane of the old word with the store data.
  always_comb begin
    merged = mem_Q;
    case (size_q)
      2'b00:   merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Next state, memory port and response values.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    mem_W        = 1'b0;
    mem_D        = '0;
    mem_A        = '0;
    case (state_q)
      IDLE: begin
        mem_A = rst_n ? req_waddr : '0;
        if (accept) begin
          if (req_trap) begin
            state_d = ERR_RESP;
          end else if (!req_we) begin
            state_d = LD_RESP;
          end else if (req_is_word) begin
            mem_W   = 1'b1;
            mem_D   = req_wdata;
            state_d = ST_RESP;
          end else begin
            state_d = MERGE;
          end
        end
      end
      LD_RESP: begin
        mem_A        = waddr_q;
        resp_valid_d = 1'b1;
        if (ao_bad) begin
          resp_err_d = 1'b1;
        end else begin
          resp_rdata_d = ld_data;
        end
        state_d = IDLE;
      end
      MERGE: begin
        mem_A = waddr_q;
        if (ao_bad) begin
          state_d = ERR_RESP;
        end else begin
          mem_W   = 1'b1;
          mem_D   = merged;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        mem_A        = waddr_q;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      ERR_RESP: begin
        mem_A        = waddr_q;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Capture the request fields on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      waddr_q <= req_waddr;
      lane_q  <= req_lane;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - randomized and directed checks of mem_lsu against a behavioural reference model
`timescale 1ns/1ps
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        ready0, ready1, rv0, rv1, err0, err1, w0, w1;
  logic [31:0] rd0, rd1, d0, d1, q0, q1;
  logic [15:0] a0, a1, ao0_r, ao1, ao0;
  logic        ao_force = 1'b0;
  logic        mem_clr = 1'b1;

  logic [31:0] mem0 [65536];
  logic [31:0] mem1 [65536];
  logic [31:0] ref0 [65536];
  logic [31:0] ref1 [65536];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign ao0 = ao_force ? 16'h0005 : ao0_r;

  mem_lsu #(.MISALIGN_TRAP(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_uns),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0),
    .resp_rdata(rd0), .resp_err(err0), .mem_A(a0), .mem_W(w0),
    .mem_D(d0), .mem_Q(q0), .mem_Ao(ao0)
  );

  mem_lsu #(.MISALIGN_TRAP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_uns),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_err(err1), .mem_A(a1), .mem_W(w1),
    .mem_D(d1), .mem_Q(q1), .mem_Ao(ao1)
  );

  // Data memory behaviour: registered read data and address echo.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (w0) mem0[a0] <= d0;
      if (w1) mem1[a1] <= d1;
    end
    q0    <= mem0[a0];
    q1    <= mem1[a1];
    ao0_r <= a0;
    ao1   <= a1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic rdy(input int s);  return s ? ready1 : ready0; endfunction
  function automatic logic rvl(input int s);  return s ? rv1 : rv0;       endfunction
  function automatic logic errs(input int s); return s ? err1 : err0;     endfunction
  function automatic logic wen(input int s);  return s ? w1 : w0;         endfunction
  function automatic logic [31:0] rdat(input int s); return s ? rd1 : rd0; endfunction
  function automatic logic [31:0] dat(input int s);  return s ? d1 : d0;   endfunction
  function automatic logic [15:0] adr(input int s);  return s ? a1 : a0;   endfunction

  // Reference behaviour of one request against the old contents of its word.
  function automatic void model(input bit trap, input bit we, input logic [1:0] size,
                                input bit uns, input logic [17:0] addr, input logic [31:0] wdata,
                                input logic [31:0] old, output logic [31:0] nw, output bit err,
                                output logic [31:0] rd, output int lat, output bit wr);
    int nb, sh;
    logic [31:0] m, v;
    bit illegal;
    illegal = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    nw = old; rd = '0; wr = 1'b0; err = 1'b0; lat = 2;
    if (trap && illegal) begin
      err = 1'b1;
      return;
    end
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    sh = 8 * ((int'(addr[1:0]) / nb) * nb);
    m  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    if (!we) begin
      v = (old >> sh) & m;
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~m;
      rd = v;
    end else begin
      nw  = (old & ~(m << sh)) | ((wdata & m) << sh);
      wr  = 1'b1;
      lat = (nb == 4) ? 2 : 3;
    end
  endfunction

  // One complete transaction on DUT s, checked cycle by cycle.
  task automatic run(input int s, input bit we, input logic [1:0] size, input bit uns,
                     input logic [17:0] addr, input logic [31:0] wdata);
    logic [15:0] wa;
    logic [31:0] old, nw, e_rd, got_word;
    bit e_err, e_wr;
    int e_lat, k, w;
    wa  = addr[17:2];
    old = s ? ref1[wa] : ref0[wa];
    model(s == 0, we, size, uns, addr, wdata, old, nw, e_err, e_rd, e_lat, e_wr);
    w = 0;
    while (!rdy(s) && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_before", {31'd0, rdy(s)}, 32'd1);
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    if (s) valid1 = 1'b1; else valid0 = 1'b1;
    #1;
    chk("accept_A", {16'd0, adr(s)}, {16'd0, wa});
    chk("accept_W", {31'd0, wen(s)}, {31'd0, e_wr && e_lat == 2});
    if (e_wr && e_lat == 2) chk("accept_D", dat(s), wdata);
    @(posedge clk); #1;
    valid0 = 1'b0; valid1 = 1'b0;
    k = 1;
    while (!rvl(s) && k < 8) begin
      chk("busy_ready", {31'd0, rdy(s)}, 32'd0);
      if (k == 1 && e_wr && e_lat == 3) begin
        chk("merge_W", {31'd0, wen(s)}, 32'd1);
        chk("merge_D", dat(s), nw);
      end
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, e_lat);
    chk("resp_valid", {31'd0, rvl(s)}, 32'd1);
    chk("resp_err", {31'd0, errs(s)}, {31'd0, e_err});
    chk("resp_rdata", rdat(s), e_rd);
    chk("pulse_ready", {31'd0, rdy(s)}, 32'd0);
    @(posedge clk); #1;
    chk("pulse_end", {31'd0, rvl(s)}, 32'd0);
    chk("ready_after", {31'd0, rdy(s)}, 32'd1);
    if (s) ref1[wa] = nw; else ref0[wa] = nw;
    got_word = s ? mem1[wa] : mem0[wa];
    chk("mem_word", got_word, nw);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ref0[i] = '0;
      ref1[i] = '0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    chk("rst_ready", {31'd0, ready0}, 32'd0);
    chk("rst_W", {31'd0, w0}, 32'd0);
    chk("rst_A", {16'd0, a0}, 32'd0);
    chk("rst_D", d0, 32'd0);
    chk("rst_valid", {31'd0, rv0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_rdata", rd0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run(0, 1'b1, 2'd2, 1'b0, 18'h00010, 32'hDEADBEEF);
    run(0, 1'b0, 2'd2, 1'b0, 18'h00010, 32'h0);
    run(0, 1'b1, 2'd2, 1'b0, 18'h00010, 32'h80FF0011);
    run(0, 1'b0, 2'd0, 1'b0, 18'h00013, 32'h0);
    run(0, 1'b0, 2'd0, 1'b1, 18'h00013, 32'h0);
    run(0, 1'b1, 2'd2, 1'b0, 18'h00010, 32'hAABBCCDD);
    run(0, 1'b1, 2'd1, 1'b0, 18'h00012, 32'h00001234);
    chk("half_merge_word", mem0[16'h0004], 32'h1234CCDD);
    run(0, 1'b0, 2'd2, 1'b0, 18'h00011, 32'h0);
    run(0, 1'b0, 2'd3, 1'b0, 18'h00010, 32'h0);
    run(1, 1'b1, 2'd2, 1'b0, 18'h00010, 32'hCAFEF00D);
    run(1, 1'b0, 2'd2, 1'b0, 18'h00011, 32'h0);

    // Reset while the sub-word write is on the port.
    run(0, 1'b1, 2'd2, 1'b0, 18'h00020, 32'h11223344);
    req_we = 1'b1; req_size = 2'd1; req_uns = 1'b0; req_addr = 18'h00022; req_wdata = 32'h0000ABCD;
    valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    chk("rmw_W_before_rst", {31'd0, w0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmw_W_in_rst", {31'd0, w0}, 32'd0);
    chk("rmw_ready_in_rst", {31'd0, ready0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rmw_ready_after", {31'd0, ready0}, 32'd1);
    chk("rmw_no_resp", {31'd0, rv0}, 32'd0);
    chk("rmw_mem_kept", mem0[16'h0008], 32'h11223344);

`ifdef MEM_LSU_ADDR_CHECK_EN
    ao_force = 1'b1;
    req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = 18'h00010; req_wdata = '0;
    valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    @(posedge clk); #1;
    chk("aochk_valid", {31'd0, rv0}, 32'd1);
    chk("aochk_err", {31'd0, err0}, 32'd1);
    chk("aochk_rdata", rd0, 32'd0);
    ao_force = 1'b0;
    @(posedge clk); #1;
`endif

    // Randomized traffic over a handful of scattered words.
    for (int n = 0; n < 300; n++) begin
      int s;
      logic [15:0] wa;
      logic [17:0] ad;
      s  = int'($urandom_range(0, 1));
      wa = 16'($urandom_range(0, 5) * 16'h2F13);
      ad = {wa, 2'($urandom_range(0, 3))};
      run(s, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ad, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
